// File: rtl/util_spi_master.sv
// rtl/util_spi_master.sv - Parametrised multi-slave SPI master engine
// Purpose: turns a valid/ready word-command stream into SPI transfers on one of
// SLAVE_NUM pin lanes, generating CS, SCLK and MOSI and capturing MISO itself.
// Ports:
//   clk, rstn            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; payload cmd_sel, cmd_wdata, cmd_last
//   rsp_valid/rsp_rdata  one-cycle pulse carrying the received word
//   busy                 high whenever the engine is not idle
//   cs/sclk/mosi/miso    per-slave SPI lanes (cs active low)
module util_spi_master #(
  parameter int   SLAVE_NUM  = 1,
  parameter int   DATA_WIDTH = 8,
  parameter int   CLK_DIV    = 4,
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0,
  parameter logic MSB_FIRST  = 1'b1,
  parameter int   CS_SETUP   = 2,
  parameter int   CS_HOLD    = 2,
  localparam int  SEL_W      = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SEL_W-1:0]      cmd_sel,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  cmd_last,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [SLAVE_NUM-1:0]  cs,
  output logic [SLAVE_NUM-1:0]  sclk,
  output logic [SLAVE_NUM-1:0]  mosi,
  input  logic [SLAVE_NUM-1:0]  miso
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W  = $clog2(2 * DATA_WIDTH);
  localparam int TIM_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TIM_W   = (TIM_MAX > 1) ? $clog2(TIM_MAX) : 1;
  localparam logic [SEL_W:0] SLAVE_LIM = (SEL_W + 1)'(SLAVE_NUM);

  // DONE is the single cycle after the final SCLK edge in which the response
  // is registered, so rsp_valid appears one cycle after SCLK returns to idle.
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, HOLD, CONT} state_t;
  state_t state, state_nxt;

  logic [SEL_W-1:0]      sel_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic                  mosi_q;
  logic                  sclk_q;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [TIM_W-1:0]      tim_cnt;

  logic accept, div_wrap, last_edge, edge_odd, sample_en, shift_en, miso_act;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d);
    return MSB_FIRST ? d[DATA_WIDTH-1] : d[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] d);
    return MSB_FIRST ? {d[DATA_WIDTH-2:0], 1'b0} : {1'b0, d[DATA_WIDTH-1:1]};
  endfunction

  assign accept    = cmd_valid & cmd_ready;
  assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_edge = div_wrap && (edge_cnt == EDGE_W'(2 * DATA_WIDTH - 1));
  // edge_cnt counts completed edges, so the edge about to happen is odd when it is even
  assign edge_odd  = ~edge_cnt[0];
  assign sample_en = (state == SHIFT) && div_wrap && (edge_odd != CPHA);
  // With CPHA=0 the first bit is preloaded, so the final (even) edge must not shift
  assign shift_en  = (state == SHIFT) && div_wrap && (edge_odd == CPHA) && !last_edge;
  assign miso_act  = miso[sel_q];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (tim_cnt == TIM_W'(CS_SETUP - 1)) state_nxt = SHIFT;
      SHIFT:   if (last_edge) state_nxt = DONE;
      DONE:    state_nxt = last_q ? HOLD : CONT;
      HOLD:    if (tim_cnt == TIM_W'(CS_HOLD - 1)) state_nxt = IDLE;
      CONT:    if (accept) state_nxt = SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sel_q     <= '0;
      last_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      mosi_q    <= 1'b0;
      sclk_q    <= CPOL;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      tim_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      cmd_ready <= (state_nxt == IDLE) || (state_nxt == CONT);

      if (((state == SETUP) || (state == HOLD)) && (state_nxt == state))
        tim_cnt <= tim_cnt + TIM_W'(1);
      else
        tim_cnt <= '0;

      if (accept) begin
        // In CONT the slave selected at the start of the burst is kept
        if (state == IDLE)
          sel_q <= ({1'b0, cmd_sel} < SLAVE_LIM) ? cmd_sel : '0;
        last_q   <= cmd_last;
        div_cnt  <= '0;
        edge_cnt <= '0;
        if (!CPHA) begin
          mosi_q <= first_bit(cmd_wdata);
          tx_q   <= shift_out(cmd_wdata);
        end else begin
          mosi_q <= 1'b0;
          tx_q   <= cmd_wdata;
        end
      end

      if (state == SHIFT) begin
        if (div_wrap) begin
          div_cnt  <= '0;
          edge_cnt <= edge_cnt + EDGE_W'(1);
          sclk_q   <= ~sclk_q;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      if (shift_en) begin
        mosi_q <= first_bit(tx_q);
        tx_q   <= shift_out(tx_q);
      end

      if (sample_en)
        rx_q <= MSB_FIRST ? {rx_q[DATA_WIDTH-2:0], miso_act} : {miso_act, rx_q[DATA_WIDTH-1:1]};

      if (state == DONE) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rx_q;
      end
    end
  end

  // Only the held lane is driven; all others sit at their idle levels
  always_comb begin
    cs   = '1;
    sclk = {SLAVE_NUM{CPOL}};
    mosi = '0;
    if (state != IDLE) begin
      cs[sel_q]   = 1'b0;
      sclk[sel_q] = sclk_q;
      mosi[sel_q] = mosi_q;
    end
  end

endmodule
